// File: rtl/datamem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package datamem_arbiter_pkg;

   localparam int DATA_W = 8;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_H = 1'b1
   } port_id_t;

endpackage

// File: rtl/datamem_arbiter_starve_ctr.sv
// Saturating up-counter with clear, increment and limit-hit flag.
// Clear together with increment loads 1, so a new run can start in the
// same cycle the previous one is discarded.
module arb_starve_ctr #(
   parameter int LIMIT = 4,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt;

   // count up to the limit and park there until cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? W'(1) : '0;
      end else if (inc && (cnt != LIM)) begin
         cnt <= cnt + W'(1);
      end
   end

   assign hit = (cnt == LIM);

endmodule

// File: rtl/datamem_arbiter.sv
// Shares the single-port 8-bit data memory between the core (C) and the
// host loader/debug path (H). Per-cycle arbitration, 1-cycle read return
// routed to the winner, starvation guard for H and H burst ownership.
// Optional build macro ARB_STATS_EN adds grant / forced-H event counters.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ARB   | per-cycle arbitration, C preferred unless H has hit starve limit
//   BURST | H owns the memory while h_req & h_lock, up to MAX_BURST grants
module datamem_arbiter
   import datamem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_BURST    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   input  logic              h_lock,
   output logic              h_gnt,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
   output logic [15:0]       c_cnt,
   output logic [15:0]       h_cnt,
   output logic [7:0]        starve_evt,
`endif
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t  state, state_nxt;
   logic        c_win, h_win;
   logic        starve_hit, burst_hit;
   logic        rd_pend;
   port_id_t    rd_owner;
   logic [DATA_W-1:0] c_hold, h_hold;

   // H waits while requesting and losing; any H grant or idle H resets the wait
   arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (h_gnt || !h_req),
      .inc   (h_req && !h_gnt),
      .hit   (starve_hit)
   );

   // burst length: loads 1 on the locking grant in ARB, counts H grants in BURST
   arb_starve_ctr #(.LIMIT(MAX_BURST)) u_burst (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   ((state == ARB) || !h_gnt),
      .inc   (h_gnt && ((state == BURST) || h_lock)),
      .hit   (burst_hit)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARB;
      else        state <= state_nxt;
   end

   // winner selection and next state; the burst exit cycle never grants H,
   // which is the gap that keeps a max-length burst from restarting at once
   always_comb begin
      state_nxt = state;
      c_win     = 1'b0;
      h_win     = 1'b0;
      case (state)
         ARB: begin
            if (c_req && !starve_hit) begin
               c_win = 1'b1;
            end else if (h_req) begin
               h_win = 1'b1;
               if (h_lock) state_nxt = BURST;
            end
         end
         BURST: begin
            if (h_req && h_lock && !burst_hit) begin
               h_win = 1'b1;
            end else begin
               c_win     = c_req;
               state_nxt = ARB;
            end
         end
         default: state_nxt = ARB;
      endcase
      if (!rst_n) begin
         c_win = 1'b0;
         h_win = 1'b0;
      end
   end

   assign c_gnt     = c_win;
   assign h_gnt     = h_win;
   assign mem_en    = c_win | h_win;
   assign mem_we    = (c_win & c_we) | (h_win & h_we);
   assign mem_addr  = h_win ? h_addr  : (c_win ? c_addr  : '0);
   assign mem_wdata = h_win ? h_wdata : (c_win ? c_wdata : '0);

   // remember who owns the read issued this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend  <= 1'b0;
         rd_owner <= PORT_C;
      end else begin
         rd_pend  <= mem_en & ~mem_we;
         rd_owner <= h_win ? PORT_H : PORT_C;
      end
   end

   assign c_rvalid = rd_pend && (rd_owner == PORT_C);
   assign h_rvalid = rd_pend && (rd_owner == PORT_H);

   // capture returned data so each port's rdata holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_hold <= '0;
         h_hold <= '0;
      end else begin
         if (c_rvalid) c_hold <= mem_rdata;
         if (h_rvalid) h_hold <= mem_rdata;
      end
   end

   assign c_rdata = c_rvalid ? mem_rdata : c_hold;
   assign h_rdata = h_rvalid ? mem_rdata : h_hold;

`ifdef ARB_STATS_EN
   logic forced_h;

   // H overriding a pending C request can only happen through starvation
   assign forced_h = (state == ARB) && h_win && c_req;

   // free-running wrap-around statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_cnt      <= '0;
         h_cnt      <= '0;
         starve_evt <= '0;
      end else begin
         c_cnt      <= c_cnt + 16'(c_win);
         h_cnt      <= h_cnt + 16'(h_win);
         starve_evt <= starve_evt + 8'(forced_h);
      end
   end
`endif

endmodule
